risc_controller: RTL and testbench
==================================

# risc_controller

- Eight-phase instruction sequencer for the Simple RISC CPU.
- Sits between the instruction register/ALU (opcode, `is_zero`) and the datapath strobes: memory select/read/write, IR load, PC increment/load, accumulator load and data-bus enable.
- Each instruction takes exactly 8 clock cycles.
- A decoded HLT parks the block in a sticky halted state until reset.

## Interface
Parameters:
- none; opcode encoding is fixed: HLT=000, SKZ=001, ADD=010, AND=011, XOR=100, LDA=101, STO=110, JMP=111.

Ports:
- `clk` input 1: rising-edge clock.
- `rst` input 1: asynchronous, active-high reset.
- `opcode` input 3: current IR opcode; guaranteed valid from phase IDLE (3) onward.
- `is_zero` input 1: accumulator-zero flag from the ALU.
- `sel` output 1: address mux select (1 = PC, 0 = IR operand).
- `rd` output 1: memory read enable.
- `ld_ir` output 1: load instruction register.
- `inc_pc` output 1: PC increment.
- `ld_pc` output 1: PC load from IR operand.
- `ld_ac` output 1: accumulator load from ALU output.
- `wr` output 1: memory write strobe.
- `data_e` output 1: accumulator drives the data bus.
- `halt` output 1: CPU halted.
- `phase` output 3: current phase, for debug and bench.

## Operation
- State: a 3-bit phase counter plus a 1-bit `halted` flag, both async-reset.
- Phase sequence: INST_ADDR(0) → INST_FETCH(1) → INST_LOAD(2) → IDLE(3) → OP_ADDR(4) → OP_FETCH(5) → ALU_OP(6) → STORE(7) → 0. Wraps 7→0 unconditionally.
- ALUOP = opcode ∈ {ADD, AND, XOR, LDA}.
- Outputs are combinational decodes of (phase, halted, opcode, is_zero). Any strobe not listed for a phase is 0.
  - Phase 0: sel.
  - Phase 1: sel, rd.
  - Phase 2: sel, rd, ld_ir.
  - Phase 3: sel, rd, ld_ir.
  - Phase 4: inc_pc; halt if opcode=HLT.
  - Phase 5: rd if ALUOP.
  - Phase 6: rd if ALUOP; inc_pc if SKZ&&is_zero; ld_pc if JMP; data_e if STO.
  - Phase 7: rd and ld_ac if ALUOP; ld_pc if JMP; wr and data_e if STO.
- Halt:
  - In phase 4 with opcode=HLT, the next edge sets `halted`. The phase counter then freezes at 4.
  - While `halted`=1: `halt`=1 and all other strobes are 0. `phase` reads 4.
  - Only `rst` clears `halted`.
- SKZ with is_zero=0: no extra strobe; the instruction completes normally.
- is_zero is sampled combinationally in phase 6 only; its value in other phases is ignored.

## Timing
- Reset values (asserted asynchronously, with no clock needed): phase=0, halted=0, sel=1, all other outputs 0.
- Reset mid-instruction: the instruction is aborted immediately, and `wr`/`ld_ac`/`ld_pc` drop in the same delta. The first edge after `rst` falls advances to phase 1.
- Instruction latency: 8 cycles from entering phase 0 to re-entering phase 0.
- PC increments once per instruction in phase 4. SKZ adds a second increment in phase 6 when taken.
- `wr` is asserted for exactly one cycle per STO.
- `ld_ac` is asserted for exactly one cycle per ALUOP instruction.
- Halt: `halt` is first asserted combinationally during phase 4. It is held continuously from the following edge.

## Configuration
- `RISC_CTRL_STEP_EN`:
  - When defined, adds input `step` (1 bit).
  - The controller holds in phase 0 (sel=1) until it samples `step`=1 on a rising edge, then runs one full 8-cycle instruction and returns to hold in phase 0.
  - A `step` level or pulse seen outside phase 0 is ignored. A `step` held high steps continuously.
- When undefined, the port is absent and the controller free-runs.

## Test plan
- Reset check: assert `rst` mid-phase 6 of an ADD → within the same timestep phase=0, sel=1, rd=ld_ac=wr=ld_pc=0. Release `rst` → phase=1 after one edge.
- ADD (opcode=010), is_zero=0 → over 8 cycles: rd high in phases 1,2,3,5,6,7; ld_ir in phases 2,3; inc_pc only in phase 4; ld_ac only in phase 7; wr never asserted.
- STO (110) → data_e in phases 6 and 7; wr only in phase 7; rd low in phases 5–7.
- SKZ (001):
  - is_zero=1 → inc_pc in phases 4 and 6 (two pulses).
  - is_zero=0 → inc_pc in phase 4 only.
- JMP (111) → ld_pc in phases 6 and 7, inc_pc only in phase 4. HLT (000) → halt asserted in phase 4, then held for ≥20 cycles with phase=4 and all other strobes 0; `rst` clears it.
- With `RISC_CTRL_STEP_EN`:
  - step=0 for 10 cycles → phase stays 0.
  - A one-cycle step pulse → exactly one 8-cycle pass, then back to hold in phase 0.

Source files
------------

// File: rtl/risc_controller.sv
// -----------------------------------------------------------------------------
// risc_controller
// Eight-phase instruction sequencer for the Simple RISC CPU. A 3-bit phase
// counter walks INST_ADDR..STORE once per instruction; datapath strobes are
// decoded combinationally from (phase, halted, opcode, is_zero). A decoded
// HLT in phase OP_ADDR sets a sticky halted flag that only rst clears.
//
// Optional feature macro: RISC_CTRL_STEP_EN
//   When defined, adds input 'step'; the sequencer holds in INST_ADDR until it
//   samples step=1 on a rising edge, then runs one full instruction.
//
// Ports:
//   clk      in   rising-edge clock
//   rst      in   asynchronous active-high reset
//   step     in   single-step request (RISC_CTRL_STEP_EN only)
//   opcode   in   [2:0] IR opcode, valid from IDLE onward
//   is_zero  in   accumulator-zero flag, used in ALU_OP only
//   sel      out  address mux select (1 = PC, 0 = IR operand)
//   rd       out  memory read enable
//   ld_ir    out  load instruction register
//   inc_pc   out  PC increment
//   ld_pc    out  PC load from IR operand
//   ld_ac    out  accumulator load from ALU
//   wr       out  memory write strobe
//   data_e   out  accumulator drives data bus
//   halt     out  CPU halted
//   phase    out  [2:0] current phase
// -----------------------------------------------------------------------------
module risc_controller (
    input  logic       clk,
    input  logic       rst,
`ifdef RISC_CTRL_STEP_EN
    input  logic       step,
`endif
    input  logic [2:0] opcode,
    input  logic       is_zero,
    output logic       sel,
    output logic       rd,
    output logic       ld_ir,
    output logic       inc_pc,
    output logic       ld_pc,
    output logic       ld_ac,
    output logic       wr,
    output logic       data_e,
    output logic       halt,
    output logic [2:0] phase
);

    localparam int unsigned PHASE_W = 3;

    localparam logic [PHASE_W-1:0] PH_INST_ADDR  = 3'd0;
    localparam logic [PHASE_W-1:0] PH_INST_FETCH = 3'd1;
    localparam logic [PHASE_W-1:0] PH_INST_LOAD  = 3'd2;
    localparam logic [PHASE_W-1:0] PH_IDLE       = 3'd3;
    localparam logic [PHASE_W-1:0] PH_OP_ADDR    = 3'd4;
    localparam logic [PHASE_W-1:0] PH_OP_FETCH   = 3'd5;
    localparam logic [PHASE_W-1:0] PH_ALU_OP     = 3'd6;
    localparam logic [PHASE_W-1:0] PH_STORE      = 3'd7;

    localparam logic [2:0] OP_HLT = 3'b000;
    localparam logic [2:0] OP_SKZ = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_LDA = 3'b101;
    localparam logic [2:0] OP_STO = 3'b110;
    localparam logic [2:0] OP_JMP = 3'b111;

    logic [PHASE_W-1:0] phase_q, phase_d;
    logic               halted_q, halted_d;
    logic               advance;
    logic               aluop;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q  <= PH_INST_ADDR;
            halted_q <= 1'b0;
        end else begin
            phase_q  <= phase_d;
            halted_q <= halted_d;
        end
    end

    // Next-state: advance every cycle, freeze at OP_ADDR once HLT is decoded
    always_comb begin
        phase_d  = phase_q;
        halted_d = halted_q;
        advance  = 1'b1;
`ifdef RISC_CTRL_STEP_EN
        if (phase_q == PH_INST_ADDR && !step) begin
            advance = 1'b0;
        end
`endif
        if (!halted_q) begin
            if (phase_q == PH_OP_ADDR && opcode == OP_HLT) begin
                halted_d = 1'b1;
            end else if (advance) begin
                phase_d = phase_q + PHASE_W'(1);
            end
        end
    end

    // Output decode
    always_comb begin
        sel    = 1'b0;
        rd     = 1'b0;
        ld_ir  = 1'b0;
        inc_pc = 1'b0;
        ld_pc  = 1'b0;
        ld_ac  = 1'b0;
        wr     = 1'b0;
        data_e = 1'b0;
        halt   = 1'b0;
        aluop  = (opcode == OP_ADD) || (opcode == OP_AND) ||
                 (opcode == OP_XOR) || (opcode == OP_LDA);
        if (halted_q) begin
            halt = 1'b1;
        end else begin
            case (phase_q)
                PH_INST_ADDR: begin
                    sel = 1'b1;
                end
                PH_INST_FETCH: begin
                    sel = 1'b1;
                    rd  = 1'b1;
                end
                PH_INST_LOAD, PH_IDLE: begin
                    sel   = 1'b1;
                    rd    = 1'b1;
                    ld_ir = 1'b1;
                end
                PH_OP_ADDR: begin
                    inc_pc = 1'b1;
                    halt   = (opcode == OP_HLT);
                end
                PH_OP_FETCH: begin
                    rd = aluop;
                end
                PH_ALU_OP: begin
                    rd     = aluop;
                    inc_pc = (opcode == OP_SKZ) && is_zero;
                    ld_pc  = (opcode == OP_JMP);
                    data_e = (opcode == OP_STO);
                end
                PH_STORE: begin
                    rd     = aluop;
                    ld_ac  = aluop;
                    ld_pc  = (opcode == OP_JMP);
                    wr     = (opcode == OP_STO);
                    data_e = (opcode == OP_STO);
                end
                default: begin
                    sel = 1'b0;
                end
            endcase
        end
    end

    assign phase = phase_q;

endmodule

// File: tb/tb_risc_controller.sv
// -----------------------------------------------------------------------------
// tb_risc_controller
// Directed + randomized bench for risc_controller. A reference model keeps the
// phase as an integer and derives expected strobes from per-instruction phase
// masks; every cycle the DUT outputs are compared against it.
// -----------------------------------------------------------------------------
module tb_risc_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] opcode;
    logic       is_zero;
    logic       sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt;
    logic [2:0] phase;
`ifdef RISC_CTRL_STEP_EN
    logic       step;
`endif

    int n_cmp = 0;
    int n_err = 0;

    int m_phase;
    bit m_halted;

    always #5 clk = ~clk;

    risc_controller dut (
        .clk     (clk),
        .rst     (rst),
`ifdef RISC_CTRL_STEP_EN
        .step    (step),
`endif
        .opcode  (opcode),
        .is_zero (is_zero),
        .sel     (sel),
        .rd      (rd),
        .ld_ir   (ld_ir),
        .inc_pc  (inc_pc),
        .ld_pc   (ld_pc),
        .ld_ac   (ld_ac),
        .wr      (wr),
        .data_e  (data_e),
        .halt    (halt),
        .phase   (phase)
    );

    // Expected {sel,rd,ld_ir,inc_pc,ld_pc,ld_ac,wr,data_e,halt}: each strobe is
    // an 8-bit mask of the phases in which it fires for this instruction.
    function automatic logic [8:0] model_strobes(int ph, bit hlt, logic [2:0] op, logic iz);
        logic [7:0] m_sel, m_rd, m_ir, m_inc, m_pc, m_ac, m_wr, m_de, m_hlt;
        bit alu;
        if (hlt) return 9'b0_0000_0001;
        alu   = (op >= 3'd2) && (op <= 3'd5);
        m_sel = 8'b0000_1111;
        m_rd  = 8'b0000_1110 | (alu ? 8'b1110_0000 : 8'h00);
        m_ir  = 8'b0000_1100;
        m_inc = 8'b0001_0000 | ((op == 3'd1 && iz) ? 8'b0100_0000 : 8'h00);
        m_pc  = (op == 3'd7) ? 8'b1100_0000 : 8'h00;
        m_ac  = alu ? 8'b1000_0000 : 8'h00;
        m_wr  = (op == 3'd6) ? 8'b1000_0000 : 8'h00;
        m_de  = (op == 3'd6) ? 8'b1100_0000 : 8'h00;
        m_hlt = (op == 3'd0) ? 8'b0001_0000 : 8'h00;
        return {m_sel[ph], m_rd[ph], m_ir[ph], m_inc[ph], m_pc[ph],
                m_ac[ph], m_wr[ph], m_de[ph], m_hlt[ph]};
    endfunction

    task automatic check(input string tag);
        logic [8:0] obs, exp;
        obs = {sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt};
        exp = model_strobes(m_phase, m_halted, opcode, is_zero);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s strobes observed=%b expected=%b", tag, obs, exp);
        end
        n_cmp++;
        assert (phase === 3'(m_phase)) else begin
            n_err++;
            $error("FAIL %s phase observed=%0d expected=%0d", tag, phase, m_phase);
        end
    endtask

    task automatic check_mask(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s phase-mask observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // One clock edge; the model follows the sequencing rules on the same edge.
    task automatic tick();
        bit stp;
        stp = 1'b1;
`ifdef RISC_CTRL_STEP_EN
        stp = step;
`endif
        @(posedge clk);
        if (!m_halted) begin
            if (m_phase == 4 && opcode == 3'd0) m_halted = 1'b1;
            else if (m_phase == 0 && !stp) m_phase = 0;
            else m_phase = (m_phase + 1) % 8;
        end
        #1;
    endtask

    task automatic model_reset();
        m_phase  = 0;
        m_halted = 1'b0;
    endtask

    // Run one instruction from phase 0; iz_mode 0/1 = fixed is_zero, 2 = random.
    task automatic run_instr(input logic [2:0] op, input int iz_mode,
                             output logic [7:0] rd_v, output logic [7:0] ir_v,
                             output logic [7:0] inc_v, output logic [7:0] pc_v,
                             output logic [7:0] ac_v, output logic [7:0] wr_v,
                             output logic [7:0] de_v);
        rd_v = '0; ir_v = '0; inc_v = '0; pc_v = '0; ac_v = '0; wr_v = '0; de_v = '0;
        opcode = op;
        for (int c = 0; c < 8; c++) begin
            is_zero = (iz_mode == 2) ? 1'($urandom % 2) : (iz_mode == 1);
            #2;
            check($sformatf("op%0d_ph%0d", op, m_phase));
            rd_v[c] = rd; ir_v[c] = ld_ir; inc_v[c] = inc_pc; pc_v[c] = ld_pc;
            ac_v[c] = ld_ac; wr_v[c] = wr; de_v[c] = data_e;
            tick();
        end
    endtask

    task automatic realign(input string tag);
        for (int i = 0; i < 8 && m_phase != 0; i++) begin
            #2;
            check(tag);
            tick();
        end
    endtask

    logic [7:0] v_rd, v_ir, v_inc, v_pc, v_ac, v_wr, v_de;

    initial begin
        rst     = 1'b1;
        opcode  = 3'd2;
        is_zero = 1'b0;
`ifdef RISC_CTRL_STEP_EN
        step    = 1'b1;
`endif
        model_reset();

        // Reset values before any clock edge
        #3;
        check("reset_async");

        @(posedge clk);
        #1;
        rst = 1'b0;
        #2;
        check("reset_release");
        tick();
        check("first_edge");
        realign("realign0");

        // ADD with is_zero=0
        run_instr(3'd2, 0, v_rd, v_ir, v_inc, v_pc, v_ac, v_wr, v_de);
        check_mask("add_rd",    v_rd,  8'hEE);
        check_mask("add_ld_ir", v_ir,  8'h0C);
        check_mask("add_inc",   v_inc, 8'h10);
        check_mask("add_ld_ac", v_ac,  8'h80);
        check_mask("add_wr",    v_wr,  8'h00);

        // Reset asserted mid phase 6 of an ADD
        opcode = 3'd2;
        for (int c = 0; c < 6; c++) begin
            #2;
            check("add_pre_rst");
            tick();
        end
        #2;
        check("add_ph6");
        rst = 1'b1;
        #1;
        model_reset();
        check("rst_mid_ph6");
        rst = 1'b0;
        tick();
        check("rst_mid_after_edge");
        realign("realign1");

        // STO
        run_instr(3'd6, 2, v_rd, v_ir, v_inc, v_pc, v_ac, v_wr, v_de);
        check_mask("sto_data_e", v_de, 8'hC0);
        check_mask("sto_wr",     v_wr, 8'h80);
        check_mask("sto_rd",     v_rd, 8'h0E);

        // SKZ taken and not taken
        run_instr(3'd1, 1, v_rd, v_ir, v_inc, v_pc, v_ac, v_wr, v_de);
        check_mask("skz_z1_inc", v_inc, 8'h50);
        run_instr(3'd1, 0, v_rd, v_ir, v_inc, v_pc, v_ac, v_wr, v_de);
        check_mask("skz_z0_inc", v_inc, 8'h10);

        // JMP
        run_instr(3'd7, 2, v_rd, v_ir, v_inc, v_pc, v_ac, v_wr, v_de);
        check_mask("jmp_ld_pc", v_pc,  8'hC0);
        check_mask("jmp_inc",   v_inc, 8'h10);

        // Random non-halting instruction stream
        for (int i = 0; i < 40; i++) begin
            run_instr(3'($urandom_range(1, 7)), 2, v_rd, v_ir, v_inc, v_pc, v_ac, v_wr, v_de);
        end

`ifdef RISC_CTRL_STEP_EN
        // Hold in phase 0 with step low
        step = 1'b0;
        for (int c = 0; c < 10; c++) begin
            #2;
            check("step_hold");
            tick();
        end
        // One-cycle pulse: exactly one pass, then hold again
        step = 1'b1;
        #2;
        check("step_pulse");
        tick();
        step = 1'b0;
        for (int c = 0; c < 10; c++) begin
            is_zero = 1'($urandom % 2);
            #2;
            check("step_pass");
            tick();
        end
        step = 1'b1;
        realign("realign_step");
`endif

        // HLT: halt in phase 4 and then sticky
        opcode = 3'd0;
        for (int c = 0; c < 26; c++) begin
            is_zero = 1'($urandom % 2);
            #2;
            check("hlt");
            tick();
        end
        n_cmp++;
        assert (halt === 1'b1 && phase === 3'd4) else begin
            n_err++;
            $error("FAIL hlt_sticky observed halt=%b phase=%0d expected halt=1 phase=4", halt, phase);
        end

        // Reset clears halt
        opcode = 3'd2;
        rst = 1'b1;
        #1;
        model_reset();
        check("hlt_rst");
        rst = 1'b0;
        tick();
        check("hlt_rst_edge");
        realign("realign2");
        run_instr(3'd5, 2, v_rd, v_ir, v_inc, v_pc, v_ac, v_wr, v_de);
        check_mask("lda_ld_ac", v_ac, 8'h80);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
